transmissor_medidas: RTL and testbench
======================================

TRANSMISSOR_MEDIDAS -- requirements
Module: transmissor_medidas

Interface
REQ-001 SHALL have parameter TERMINADOR, default 7'h23 ('#'), the ASCII frame terminator.
REQ-002 SHALL have parameter SEPARADOR, default 7'h2C (','), the ASCII field separator.
REQ-003 SHALL have port clock, input, 1: the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port partida, input, 1: one-cycle pulse requesting transmission of one frame.
REQ-006 SHALL have ports medida1, medida2, medida3, input, 12 each: 3-digit BCD distances, [11:8] hundreds, [7:4] tens, [3:0] units.
REQ-007 SHALL have port tx_pronto, input, 1: one-cycle pulse from the serial transmitter, meaning the current character has finished.
REQ-008 SHALL have port tx_partida, output, 1: one-cycle pulse starting transmission of tx_dado.
REQ-009 SHALL have port tx_dado, output, 7: ASCII character for the serial transmitter.
REQ-010 SHALL have port ocupado, output, 1: high while a frame is in progress, from CARREGA through FIM.
REQ-011 SHALL have port pronto, output, 1: one-cycle pulse when the frame is complete.
REQ-012 SHALL have port db_estado, output, 4: current FSM state code, for the hexa7seg display.

Function
REQ-013 SHALL send the frame d1h d1t d1u SEP d2h d2t d2u SEP d3h d3t d3u TERMINADOR, 12 characters, with an index counter of 0..11.
REQ-014 SHALL encode a BCD nibble 0..9 as 7'h30+nibble, and a nibble 10..15 as 7'h3F ('?').
REQ-015 SHALL latch medida1..3 into internal registers on the CARREGA cycle; input changes after that SHALL NOT affect the frame.
REQ-016 SHALL use the FSM states INICIAL=0, CARREGA=1, ENVIA=2, ESPERA=3, PROXIMO=4, FIM=5, with db_estado equal to the state code.
REQ-017 SHALL follow these transitions:
- INICIAL -> CARREGA on partida=1
- CARREGA -> ENVIA, index=0
- ENVIA -> ESPERA unconditionally
- ESPERA -> PROXIMO on tx_pronto=1
- PROXIMO -> ENVIA with index+1 if index<last; otherwise -> FIM
- FIM -> INICIAL
REQ-018 SHALL assert tx_partida only during the single ENVIA cycle; first tx_partida occurs 2 cycles after the partida pulse.
REQ-019 SHALL hold tx_dado stable from ENVIA until leaving ESPERA; tx_dado SHALL be 7'h00 in INICIAL.
REQ-020 SHALL assert pronto only during the single FIM cycle.
REQ-021 SHALL ignore partida in every state other than INICIAL; no frame is queued.
REQ-022 SHALL ignore tx_pronto outside ESPERA.
REQ-023 SHALL, when tx_pronto arrives in the same cycle as ENVIA, not count it; the FSM waits for a later tx_pronto in ESPERA.
REQ-024 SHALL remain in ESPERA indefinitely while tx_pronto is absent; there is no timeout.

Reset
REQ-025 SHALL, on reset=1 at a clock edge, enter INICIAL, zero index, latched measurements and tx_dado, and drive tx_partida=0, pronto=0, ocupado=0, db_estado=0.
REQ-026 SHALL, on reset mid-frame, abort the frame with no pronto pulse; reset has priority over partida in the same cycle.

Configuration
REQ-027 SHALL support the macro TRANSMISSOR_CHECKSUM_EN.
- When defined: the frame has 13 characters; after TERMINADOR one extra character is sent, equal to the bitwise XOR of the 12 preceding 7-bit characters, and the last index is 12.
- When undefined: the frame has 12 characters, the last index is 11, and no checksum logic is present.

Verification
REQ-028 SHALL cover this case: medida1=12'h123, medida2=12'h045, medida3=12'h300, partida pulse, tx_pronto returned 3 cycles after each tx_partida -> characters "123,045,300#" in order, 12 tx_partida pulses, one pronto pulse.
REQ-029 SHALL cover this case: medida1=12'h1A9, with the other fields 12'h000 -> second character 7'h3F, all else per encoding.
REQ-030 SHALL cover this case: partida pulsed again while in ESPERA at index 4 -> no restart, frame completes normally, and only one pronto pulse occurs.
REQ-031 SHALL cover this case: reset asserted while in ESPERA at index 6 -> next cycle state 0, tx_partida=0, ocupado=0, and no pronto; a new partida then restarts at character 0.
REQ-032 SHALL cover this case: tx_pronto withheld for 1000 cycles -> FSM stays in ESPERA (db_estado=3) with tx_dado unchanged.
REQ-033 SHALL cover this case: with TRANSMISSOR_CHECKSUM_EN and the REQ-028 stimulus -> 13th character equals the XOR of the 12 frame characters, and pronto follows it.

Source files
------------

// File: rtl/transmissor_medidas.sv
// Serialises three 3-digit BCD distances as an ASCII frame "ddd,ddd,ddd#" for a UART transmitter.
// Define TRANSMISSOR_CHECKSUM_EN to append an XOR checksum character after the terminator.
module transmissor_medidas #(
  parameter logic [6:0] TERMINADOR = 7'h23,
  parameter logic [6:0] SEPARADOR  = 7'h2C
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        partida,
  input  logic [11:0] medida1,
  input  logic [11:0] medida2,
  input  logic [11:0] medida3,
  input  logic        tx_pronto,
  output logic        tx_partida,
  output logic [6:0]  tx_dado,
  output logic        ocupado,
  output logic        pronto,
  output logic [3:0]  db_estado
);

  typedef enum logic [3:0] {
    INICIAL = 4'd0,
    CARREGA = 4'd1,
    ENVIA   = 4'd2,
    ESPERA  = 4'd3,
    PROXIMO = 4'd4,
    FIM     = 4'd5
  } estado_t;

`ifdef TRANSMISSOR_CHECKSUM_EN
  localparam logic [3:0] ULTIMO = 4'd12;
`else
  localparam logic [3:0] ULTIMO = 4'd11;
`endif

  estado_t     estado;
  logic [3:0]  indice;
  logic [11:0] reg_m1, reg_m2, reg_m3;
  logic [3:0]  prox_indice;
  logic [11:0] sel_m1, sel_m2, sel_m3;
  logic [6:0]  prox_char;
`ifdef TRANSMISSOR_CHECKSUM_EN
  logic [6:0]  soma;
`endif

  function automatic logic [6:0] codifica(input logic [3:0] n);
    if (n <= 4'd9)
      codifica = 7'h30 + {3'b000, n};
    else
      codifica = 7'h3F;
  endfunction

  function automatic logic [6:0] caractere(input logic [3:0] idx, input logic [11:0] a,
                                           input logic [11:0] b, input logic [11:0] c);
    case (idx)
      4'd0:    caractere = codifica(a[11:8]);
      4'd1:    caractere = codifica(a[7:4]);
      4'd2:    caractere = codifica(a[3:0]);
      4'd3:    caractere = SEPARADOR;
      4'd4:    caractere = codifica(b[11:8]);
      4'd5:    caractere = codifica(b[7:4]);
      4'd6:    caractere = codifica(b[3:0]);
      4'd7:    caractere = SEPARADOR;
      4'd8:    caractere = codifica(c[11:8]);
      4'd9:    caractere = codifica(c[7:4]);
      4'd10:   caractere = codifica(c[3:0]);
      4'd11:   caractere = TERMINADOR;
      default: caractere = 7'h00;
    endcase
  endfunction

  // The first character is built from the live inputs in CARREGA, the same edge that latches them.
  always_comb begin
    prox_indice = (estado == CARREGA) ? 4'd0 : indice + 4'd1;
    sel_m1      = (estado == CARREGA) ? medida1 : reg_m1;
    sel_m2      = (estado == CARREGA) ? medida2 : reg_m2;
    sel_m3      = (estado == CARREGA) ? medida3 : reg_m3;
    prox_char   = caractere(prox_indice, sel_m1, sel_m2, sel_m3);
`ifdef TRANSMISSOR_CHECKSUM_EN
    if (prox_indice == ULTIMO)
      prox_char = soma;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado     <= INICIAL;
      indice     <= 4'd0;
      reg_m1     <= 12'h000;
      reg_m2     <= 12'h000;
      reg_m3     <= 12'h000;
      tx_dado    <= 7'h00;
      tx_partida <= 1'b0;
      ocupado    <= 1'b0;
      pronto     <= 1'b0;
`ifdef TRANSMISSOR_CHECKSUM_EN
      soma       <= 7'h00;
`endif
    end else begin
      tx_partida <= 1'b0;
      pronto     <= 1'b0;
      case (estado)
        INICIAL: begin
          if (partida) begin
            estado  <= CARREGA;
            ocupado <= 1'b1;
          end
        end
        CARREGA: begin
          reg_m1     <= medida1;
          reg_m2     <= medida2;
          reg_m3     <= medida3;
          indice     <= 4'd0;
          tx_dado    <= prox_char;
          tx_partida <= 1'b1;
          estado     <= ENVIA;
`ifdef TRANSMISSOR_CHECKSUM_EN
          soma       <= prox_char;
`endif
        end
        ENVIA: begin
          estado <= ESPERA;
        end
        ESPERA: begin
          if (tx_pronto)
            estado <= PROXIMO;
        end
        PROXIMO: begin
          if (indice < ULTIMO) begin
            indice     <= prox_indice;
            tx_dado    <= prox_char;
            tx_partida <= 1'b1;
            estado     <= ENVIA;
`ifdef TRANSMISSOR_CHECKSUM_EN
            if (prox_indice != ULTIMO)
              soma <= soma ^ prox_char;
`endif
          end else begin
            estado <= FIM;
            pronto <= 1'b1;
          end
        end
        FIM: begin
          estado  <= INICIAL;
          ocupado <= 1'b0;
          tx_dado <= 7'h00;
        end
        default: begin
          estado  <= INICIAL;
          ocupado <= 1'b0;
          tx_dado <= 7'h00;
        end
      endcase
    end
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_transmissor_medidas.sv
// Scoreboard bench for transmissor_medidas: expected characters are queued per frame and
// popped by a monitor on every tx_partida pulse; the monitor also emulates the UART's tx_pronto.
module tb_transmissor_medidas;

`ifdef TRANSMISSOR_CHECKSUM_EN
  localparam int FRAME_LEN = 13;
`else
  localparam int FRAME_LEN = 12;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        partida;
  logic [11:0] medida1, medida2, medida3;
  logic        tx_pronto;
  logic        tx_partida;
  logic [6:0]  tx_dado;
  logic        ocupado;
  logic        pronto;
  logic [3:0]  db_estado;

  logic [6:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int tx_count = 0;
  int pronto_count = 0;
  int resp_cnt = 0;
  bit auto_resp = 1'b1;

  always #5 clock = ~clock;

  transmissor_medidas dut (
    .clock      (clock),
    .reset      (reset),
    .partida    (partida),
    .medida1    (medida1),
    .medida2    (medida2),
    .medida3    (medida3),
    .tx_pronto  (tx_pronto),
    .tx_partida (tx_partida),
    .tx_dado    (tx_dado),
    .ocupado    (ocupado),
    .pronto     (pronto),
    .db_estado  (db_estado)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor and UART model: returns tx_pronto 3 cycles after each tx_partida when enabled.
  task automatic monitorLoop();
    forever begin
      @(negedge clock);
      if (auto_resp) begin
        tx_pronto = 1'b0;
        if (resp_cnt > 0) begin
          resp_cnt--;
          if (resp_cnt == 0)
            tx_pronto = 1'b1;
        end
      end
      if (tx_partida) begin
        tx_count++;
        if (auto_resp)
          resp_cnt = 3;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_char: got 0x%0h, expected no character", tx_dado);
        end else begin
          checkOutput("frame_char", {25'd0, tx_dado}, {25'd0, exp_q.pop_front()});
        end
      end
      if (pronto)
        pronto_count++;
    end
  endtask

  task automatic applyStimulus(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c,
                               input string s);
    logic [6:0] x;
    byte ch;
    x = 7'h00;
    medida1 = a;
    medida2 = b;
    medida3 = c;
    for (int i = 0; i < s.len(); i++) begin
      ch = s[i];
      exp_q.push_back(ch[6:0]);
      x = x ^ ch[6:0];
    end
`ifdef TRANSMISSOR_CHECKSUM_EN
    exp_q.push_back(x);
`endif
    @(negedge clock);
    partida = 1'b1;
    @(negedge clock);
    partida = 1'b0;
    checkOutput("carrega_state", {28'd0, db_estado}, 32'd1);
    checkOutput("carrega_ocupado", {31'd0, ocupado}, 32'd1);
    @(negedge clock);
    medida1 = 12'hFFF;
    medida2 = 12'hFFF;
    medida3 = 12'hFFF;
    checkOutput("first_tx_partida", {31'd0, tx_partida}, 32'd1);
    checkOutput("envia_state", {28'd0, db_estado}, 32'd2);
  endtask

  task automatic waitFrameEnd(input int p0, input int t0);
    int n;
    n = 0;
    while (pronto_count == p0 && n < 3000) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("[TB] FAIL frame_timeout: got no pronto after %0d cycles, expected one", n);
    end
    checkOutput("pronto_pulses", pronto_count - p0, 32'd1);
    checkOutput("tx_pulses", tx_count - t0, FRAME_LEN);
    checkOutput("queue_left", exp_q.size(), 32'd0);
    @(negedge clock);
    checkOutput("idle_state", {28'd0, db_estado}, 32'd0);
    checkOutput("idle_ocupado", {31'd0, ocupado}, 32'd0);
    checkOutput("idle_tx_dado", {25'd0, tx_dado}, 32'd0);
  endtask

  task automatic waitTxCount(input int target);
    int n;
    n = 0;
    while (tx_count < target && n < 3000) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("[TB] FAIL tx_wait_timeout: got %0d pulses, expected %0d", tx_count, target);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int p0, t0;
    logic [6:0] held;
    reset = 1'b1;
    partida = 1'b0;
    tx_pronto = 1'b0;
    medida1 = 12'h000;
    medida2 = 12'h000;
    medida3 = 12'h000;
    fork
      monitorLoop();
    join_none
    repeat (3) @(negedge clock);
    checkOutput("reset_state", {28'd0, db_estado}, 32'd0);
    checkOutput("reset_tx_dado", {25'd0, tx_dado}, 32'd0);
    checkOutput("reset_tx_partida", {31'd0, tx_partida}, 32'd0);
    checkOutput("reset_ocupado", {31'd0, ocupado}, 32'd0);
    checkOutput("reset_pronto", {31'd0, pronto}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Basic frame, inputs scrambled right after the load cycle
    p0 = pronto_count; t0 = tx_count;
    applyStimulus(12'h123, 12'h045, 12'h300, "123,045,300#");
    waitFrameEnd(p0, t0);

    // Non-decimal nibble encodes as '?'
    p0 = pronto_count; t0 = tx_count;
    applyStimulus(12'h1A9, 12'h000, 12'h000, "1?9,000,000#");
    waitFrameEnd(p0, t0);

    // partida during ESPERA at index 4 must not restart nor queue a frame
    p0 = pronto_count; t0 = tx_count;
    applyStimulus(12'h555, 12'h666, 12'h777, "555,666,777#");
    waitTxCount(t0 + 5);
    @(negedge clock);
    checkOutput("espera_idx4_state", {28'd0, db_estado}, 32'd3);
    partida = 1'b1;
    @(negedge clock);
    partida = 1'b0;
    waitFrameEnd(p0, t0);
    repeat (10) @(negedge clock);
    #1;
    checkOutput("no_queued_frame", tx_count - t0, FRAME_LEN);
    checkOutput("single_pronto", pronto_count - p0, 32'd1);

    // Reset at index 6 aborts the frame; reset wins over a simultaneous partida
    p0 = pronto_count; t0 = tx_count;
    applyStimulus(12'h111, 12'h222, 12'h333, "111,222,333#");
    waitTxCount(t0 + 7);
    @(negedge clock);
    checkOutput("espera_idx6_state", {28'd0, db_estado}, 32'd3);
    reset = 1'b1;
    partida = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    partida = 1'b0;
    checkOutput("abort_state", {28'd0, db_estado}, 32'd0);
    checkOutput("abort_tx_partida", {31'd0, tx_partida}, 32'd0);
    checkOutput("abort_ocupado", {31'd0, ocupado}, 32'd0);
    checkOutput("abort_tx_dado", {25'd0, tx_dado}, 32'd0);
    exp_q.delete();
    repeat (10) @(negedge clock);
    #1;
    checkOutput("abort_no_pronto", pronto_count - p0, 32'd0);
    checkOutput("abort_stays_idle", {28'd0, db_estado}, 32'd0);

    p0 = pronto_count; t0 = tx_count;
    applyStimulus(12'h400, 12'h050, 12'h006, "400,050,006#");
    waitFrameEnd(p0, t0);

    // tx_pronto during ENVIA is ignored, then withheld for 1000 cycles
    auto_resp = 1'b0;
    tx_pronto = 1'b0;
    p0 = pronto_count; t0 = tx_count;
    applyStimulus(12'h987, 12'h654, 12'h321, "987,654,321#");
    tx_pronto = 1'b1;
    @(negedge clock);
    tx_pronto = 1'b0;
    checkOutput("envia_pronto_ignored", {28'd0, db_estado}, 32'd3);
    held = tx_dado;
    checkOutput("held_char", {25'd0, held}, 32'h39);
    repeat (1000) @(negedge clock);
    #1;
    checkOutput("withhold_state", {28'd0, db_estado}, 32'd3);
    checkOutput("withhold_tx_dado", {25'd0, tx_dado}, 32'h39);
    checkOutput("withhold_tx_count", tx_count - t0, 32'd1);
    @(negedge clock);
    tx_pronto = 1'b1;
    @(negedge clock);
    tx_pronto = 1'b0;
    auto_resp = 1'b1;
    waitFrameEnd(p0, t0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
